// File: rtl/dma_frame_sequencer.sv
// dma_frame_sequencer: per-frame buffer selection and Avalon-MM reprogramming of the stream DMA
module dma_frame_sequencer #(
  parameter int ADDR_WIDTH  = 24,
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_enable,
  input  logic [NUM_BUFFERS*ADDR_WIDTH-1:0] cfg_buf_addr,
  input  logic [29:0]                     cfg_words,
  input  logic                            frame_start,
  input  logic                            wr_frame_done,
  input  logic [IDX_W-1:0]                wr_frame_idx,
  output logic [IDX_W-1:0]                wr_buf_idx,
  output logic [IDX_W-1:0]                rd_buf_idx,
  output logic                            busy,
  output logic                            frame_repeat,
  output logic                            frame_skip,
  output logic                            start_drop,
  output logic [4:0]                      dma_address,
  output logic                            dma_write,
  output logic [31:0]                     dma_writedata,
  output logic [3:0]                      dma_byteenable,
  input  logic                            dma_waitrequest
);
  typedef enum logic [2:0] {IDLE, DIS, ADDR, WORDS, EN, OFF} state_t;
  state_t state, state_nxt;
  logic pending, ready_valid, armed, start, consume, done;
  logic [IDX_W-1:0] ready_idx, wr_nxt;
  logic [4:0] addr_nxt;
  logic [31:0] data_nxt;
  assign dma_byteenable = 4'hF;
  assign start = state == IDLE && cfg_enable && (frame_start || pending);
  assign consume = start && ready_valid;
  assign done = dma_write && !dma_waitrequest;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? DIS : (!cfg_enable && armed) ? OFF : IDLE;
      DIS:     state_nxt = done ? ADDR : DIS;
      ADDR:    state_nxt = done ? WORDS : ADDR;
      WORDS:   state_nxt = done ? EN : WORDS;
      EN:      state_nxt = done ? IDLE : EN;
      OFF:     state_nxt = done ? IDLE : OFF;
      default: state_nxt = IDLE;
    endcase
  end
  // bus outputs are registered from the state being entered, so a stalled write re-registers identical values
  always_comb begin
    addr_nxt = state_nxt == ADDR ? 5'h00 : state_nxt == WORDS ? 5'h04 : 5'h08;
    data_nxt = state_nxt == ADDR  ? 32'(cfg_buf_addr[int'(rd_buf_idx)*ADDR_WIDTH +: ADDR_WIDTH]) :
               state_nxt == WORDS ? {2'b0, cfg_words} :
               state_nxt == EN    ? 32'd1 : 32'd0;
  end
  always_comb begin
    wr_nxt = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--)
      if (IDX_W'(i) != rd_buf_idx && !(NUM_BUFFERS >= 3 && ready_valid && IDX_W'(i) == ready_idx))
        wr_nxt = IDX_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dma_write     <= 1'b0;
      dma_address   <= '0;
      dma_writedata <= '0;
      busy          <= 1'b0;
      rd_buf_idx    <= '0;
      wr_buf_idx    <= IDX_W'(1);
      ready_idx     <= '0;
      ready_valid   <= 1'b0;
      pending       <= 1'b0;
      armed         <= 1'b0;
      frame_repeat  <= 1'b0;
      frame_skip    <= 1'b0;
      start_drop    <= 1'b0;
    end else begin
      state         <= state_nxt;
      dma_write     <= state_nxt != IDLE;
      busy          <= state_nxt != IDLE;
      dma_address   <= addr_nxt;
      dma_writedata <= data_nxt;
      wr_buf_idx    <= wr_nxt;
      frame_repeat  <= start && !ready_valid;
      frame_skip    <= wr_frame_done && ready_valid && !consume;
      start_drop    <= !start && frame_start && cfg_enable && state != IDLE && pending;
      if (consume) rd_buf_idx <= ready_idx;
      if (start) pending <= 1'b0;
      else if (frame_start && cfg_enable && state != IDLE) pending <= 1'b1;
      if (wr_frame_done) begin
        ready_idx   <= wr_frame_idx;
        ready_valid <= 1'b1;
      end else if (consume) ready_valid <= 1'b0;
      if (state == EN && done) armed <= 1'b1;
      else if (state_nxt == OFF) armed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dma_frame_sequencer.sv
// tb_dma_frame_sequencer: directed checks of buffer selection, write sequence, stalls and pulses
module tb_dma_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n, cfg_enable, frame_start, wr_frame_done, dma_waitrequest;
  logic [71:0] cfg_buf_addr;
  logic [29:0] cfg_words;
  logic [1:0] wr_frame_idx, wr_buf_idx, rd_buf_idx;
  logic busy, frame_repeat, frame_skip, start_drop, dma_write;
  logic [4:0] dma_address;
  logic [31:0] dma_writedata;
  logic [3:0] dma_byteenable;
  int errors = 0;
  int checks = 0;
  dma_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_buf_addr(cfg_buf_addr),
    .cfg_words(cfg_words), .frame_start(frame_start), .wr_frame_done(wr_frame_done),
    .wr_frame_idx(wr_frame_idx), .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx),
    .busy(busy), .frame_repeat(frame_repeat), .frame_skip(frame_skip), .start_drop(start_drop),
    .dma_address(dma_address), .dma_write(dma_write), .dma_writedata(dma_writedata),
    .dma_byteenable(dma_byteenable), .dma_waitrequest(dma_waitrequest)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".write"}, 32'(dma_write), 32'd1);
    check({tag, ".addr"}, 32'(dma_address), 32'(a));
    check({tag, ".data"}, dma_writedata, d);
  endtask
  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; frame_start = 1'b0; wr_frame_done = 1'b0;
    wr_frame_idx = '0; dma_waitrequest = 1'b0; cfg_words = 30'd1024;
    cfg_buf_addr = {24'h200000, 24'h100000, 24'h000000};
    step(2);
    check("rst.write", 32'(dma_write), 32'd0);
    check("rst.addr", 32'(dma_address), 32'd0);
    check("rst.data", dma_writedata, 32'd0);
    check("rst.rd", 32'(rd_buf_idx), 32'd0);
    check("rst.wr", 32'(wr_buf_idx), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.pulses", {29'd0, frame_repeat, frame_skip, start_drop}, 32'd0);
    check("rst.be", 32'(dma_byteenable), 32'hF);
    rst_n = 1'b1; cfg_enable = 1'b1;
    step();
    // first frame with nothing written: repeat buffer 0
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check_wr("f1.dis", 5'h08, 32'd0);
    check("f1.repeat", 32'(frame_repeat), 32'd1);
    check("f1.busy", 32'(busy), 32'd1);
    step(); check_wr("f1.addr", 5'h00, 32'h000000);
    check("f1.repeat_off", 32'(frame_repeat), 32'd0);
    step(); check_wr("f1.words", 5'h04, 32'd1024);
    step(); check_wr("f1.en", 5'h08, 32'd1);
    check("f1.busy_en", 32'(busy), 32'd1);
    step();
    check("f1.idle_write", 32'(dma_write), 32'd0);
    check("f1.idle_busy", 32'(busy), 32'd0);
    check("f1.rd", 32'(rd_buf_idx), 32'd0);
    check("f1.wr", 32'(wr_buf_idx), 32'd1);
    // buffer 1 completed, then picked up
    wr_frame_done = 1'b1; wr_frame_idx = 2'd1; step(); wr_frame_done = 1'b0;
    step(); check("f2.wr_pre", 32'(wr_buf_idx), 32'd2);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check_wr("f2.dis", 5'h08, 32'd0);
    check("f2.repeat", 32'(frame_repeat), 32'd0);
    step(); check_wr("f2.addr", 5'h00, 32'h100000);
    check("f2.rd", 32'(rd_buf_idx), 32'd1);
    check("f2.wr", 32'(wr_buf_idx), 32'd0);
    step(3);
    check("f2.idle", 32'(dma_write), 32'd0);
    // waitrequest stall on the ADDR write
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step(); check_wr("st.addr0", 5'h00, 32'h100000);
    dma_waitrequest = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(); check_wr($sformatf("st.hold%0d", k), 5'h00, 32'h100000);
    end
    dma_waitrequest = 1'b0;
    step(); check_wr("st.words", 5'h04, 32'd1024);
    step(); check_wr("st.en", 5'h08, 32'd1);
    step(); check("st.idle", 32'(dma_write), 32'd0);
    // three starts while busy: one pending, two dropped
    frame_start = 1'b1; step();
    check("pd.e0", 32'(busy), 32'd1);
    step(); check("pd.drop1", 32'(start_drop), 32'd0);
    step(); check("pd.drop2", 32'(start_drop), 32'd1);
    step(); frame_start = 1'b0;
    check("pd.drop3", 32'(start_drop), 32'd1);
    step(); check("pd.gap_write", 32'(dma_write), 32'd0);
    check("pd.drop_off", 32'(start_drop), 32'd0);
    step(); check_wr("pd.rerun", 5'h08, 32'd0);
    step(3); check_wr("pd.rerun_en", 5'h08, 32'd1);
    step(); check("pd.idle", 32'(dma_write), 32'd0);
    step(); check("pd.no_third", 32'(dma_write), 32'd0);
    // skip: buffer 1 then buffer 2 before a frame_start
    wr_frame_done = 1'b1; wr_frame_idx = 2'd1; step();
    check("sk.first", 32'(frame_skip), 32'd0);
    wr_frame_idx = 2'd2; step(); wr_frame_done = 1'b0;
    check("sk.second", 32'(frame_skip), 32'd1);
    step(); check("sk.off", 32'(frame_skip), 32'd0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step(); check_wr("sk.addr", 5'h00, 32'h200000);
    check("sk.rd", 32'(rd_buf_idx), 32'd2);
    step(3);
    // same-cycle consume and done: old index used, new one stays ready
    wr_frame_done = 1'b1; wr_frame_idx = 2'd0; step();
    wr_frame_idx = 2'd1; frame_start = 1'b1; step();
    wr_frame_done = 1'b0; frame_start = 1'b0;
    check("sc.skip", 32'(frame_skip), 32'd0);
    check("sc.repeat", 32'(frame_repeat), 32'd0);
    step(); check_wr("sc.addr", 5'h00, 32'h000000);
    check("sc.rd", 32'(rd_buf_idx), 32'd0);
    check("sc.wr", 32'(wr_buf_idx), 32'd2);
    step(3);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("sc.next_repeat", 32'(frame_repeat), 32'd0);
    step(); check_wr("sc.next_addr", 5'h00, 32'h100000);
    step(3);
    // disable while idle: one disable write, then silence
    cfg_enable = 1'b0; step();
    check_wr("off.dis", 5'h08, 32'd0);
    step(); check("off.done", 32'(dma_write), 32'd0);
    step(); check("off.quiet", 32'(dma_write), 32'd0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("off.ignored", 32'(dma_write), 32'd0);
    check("off.no_repeat", 32'(frame_repeat), 32'd0);
    step(); check("off.ignored2", 32'(dma_write), 32'd0);
    // asynchronous reset mid-sequence
    cfg_enable = 1'b1; frame_start = 1'b1; step(); frame_start = 1'b0;
    step(); check("ar.active", 32'(dma_write), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("ar.write", 32'(dma_write), 32'd0);
    check("ar.busy", 32'(busy), 32'd0);
    step(); rst_n = 1'b1;
    step(); check("ar.after", 32'(dma_write), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_frame_sequencer.md
Name: dma_frame_sequencer

Overview:
- Per-frame controller for the AXI-to-stream DMA; acts as Avalon-MM master on the DMA control port (0x00 start address, 0x04 word count, 0x08 enable).
- On each display frame_start it selects the newest completely written frame buffer, then reprograms and restarts the DMA.
- Tracks writer-side completion so reader and writer never share a buffer (double/triple buffering); sits between the video-in writer, the DSI timing generator and the DMA.

Parameters:
ADDR_WIDTH, 24, width of frame buffer base addresses
NUM_BUFFERS, 3, number of frame buffers, legal 2..4
IDX_W, 2, buffer index width, must satisfy 2^IDX_W >= NUM_BUFFERS

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_enable  in  1  sequencer enable (level)
cfg_buf_addr  in  NUM_BUFFERS*ADDR_WIDTH  flattened base addresses; buffer i at [i*ADDR_WIDTH +: ADDR_WIDTH]
cfg_words  in  30  words per frame, written to DMA 0x04
frame_start  in  1  single-cycle pulse requesting the next frame
wr_frame_done  in  1  single-cycle pulse: writer completed buffer wr_frame_idx
wr_frame_idx  in  IDX_W  index of the completed buffer
wr_buf_idx  out  IDX_W  buffer the writer must fill next (registered)
rd_buf_idx  out  IDX_W  buffer currently programmed into the DMA
busy  out  1  high while a programming sequence is in progress
frame_repeat  out  1  pulse: frame_start found no new buffer, current buffer reused
frame_skip  out  1  pulse: ready buffer replaced before it was consumed
start_drop  out  1  pulse: frame_start lost because one was already pending
dma_address  out  5  Avalon address
dma_write  out  1  Avalon write
dma_writedata  out  32  Avalon write data
dma_byteenable  out  4  constant 4'hF
dma_waitrequest  in  1  Avalon waitrequest

Behaviour:
- Reset values: dma_write 0, dma_address 0, dma_writedata 0, rd_buf_idx 0, wr_buf_idx 1, busy 0, all pulses 0, ready_valid 0, pending 0. Reset mid-sequence aborts immediately; no write is completed.
- FSM states: IDLE, DIS, ADDR, WORDS, EN, OFF.
- IDLE:
  - If cfg_enable and (frame_start or pending): select the buffer, clear pending, go to DIS.
  - Else if cfg_enable fell since the last EN completion: go to OFF.
- Buffer selection (performed in the IDLE exit cycle):
  - If ready_valid: rd_buf_idx <= ready_idx and ready_valid is cleared.
  - Else: rd_buf_idx is unchanged and frame_repeat pulses for 1 cycle.
- Write sequence, each write held until dma_waitrequest is sampled low:
  - DIS: address 0x08, data 0.
  - ADDR: address 0x00, data = zero-extended cfg_buf_addr[rd_buf_idx].
  - WORDS: address 0x04, data {2'b0, cfg_words}.
  - EN: address 0x08, data 1.
  - After EN completes, return to IDLE.
- OFF: one write of 0x08 with data 0, then IDLE; no further writes until cfg_enable rises.
- Outputs are registered. If frame_start arrives in IDLE at cycle T with waitrequest held low: dma_write is high T+1..T+4, busy is high T+1..T+4, and the FSM is back in IDLE at T+5.
- dma_write, dma_address and dma_writedata stay stable while dma_waitrequest is high. Between writes, dma_write deasserts for 0 cycles (back-to-back allowed).
- frame_start while busy: sets pending. If pending is already set, start_drop pulses and the new request is dropped.
- frame_start while cfg_enable is low: ignored, no pulses.
- wr_frame_done: ready_idx <= wr_frame_idx, ready_valid <= 1. If ready_valid was already 1 and is not being consumed that cycle, frame_skip pulses.
  - Same-cycle consume and done: consume takes the old ready_idx; the new done then leaves ready_valid = 1 with the new index.
- wr_buf_idx is recomputed every cycle (registered, 1-cycle latency):
  - NUM_BUFFERS >= 3: the lowest index not equal to rd_buf_idx and not equal to ready_idx (when ready_valid).
  - NUM_BUFFERS = 2: the index other than rd_buf_idx.
- wr_frame_idx equal to rd_buf_idx is a writer protocol error: the buffer is still accepted as ready, with no other effect.
- Indices >= NUM_BUFFERS are never produced.

Test Plan:
- Reset, then cfg_enable=1, bufs {0x000000,0x100000,0x200000}, cfg_words=1024, frame_start with no done. Required: writes (0x08,0),(0x00,0),(0x04,1024),(0x08,1) on 4 consecutive cycles; frame_repeat=1; rd_buf_idx=0; wr_buf_idx=1.
- wr_frame_done idx1, then frame_start. Required: ADDR write carries 0x100000; rd_buf_idx=1; wr_buf_idx=0; no frame_repeat.
- dma_waitrequest held high 3 cycles on the ADDR write. Required: address 0x00 and data stay stable; WORDS write starts the cycle after waitrequest is sampled low.
- Three frame_start pulses during busy. Required: one pending sequence runs after the current one; start_drop pulses twice.
- done idx1 then done idx2 before frame_start. Required: frame_skip pulses once; next frame uses 0x200000; same-cycle done + frame_start selects the old index and leaves ready_valid=1.
- cfg_enable dropped while idle after a run. Required: single write (0x08,0); no writes on later frame_start; asserting rst_n low mid-sequence forces dma_write=0 immediately.
